// File: rtl/keccak_padder_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pkg_keccak
// Purpose   : Shared constants and types for the Keccak message padder.
//             Word width, rate, words-per-block and the pad byte values.
// Config    : KECCAK_PAD_SHA3_EN selects the SHA-3 domain pad byte (0x06)
//             instead of the original Keccak pad byte (0x01).
// Revision  : 1.0 - initial release
// ============================================================================
package pkg_keccak;

  localparam int IN_BUF_SIZE    = 64;
  localparam int RATE_BITS      = 1024;
  localparam int RATE_BYTES     = RATE_BITS / 8;
  localparam int WPB            = RATE_BITS / IN_BUF_SIZE;
  localparam int BYTES_PER_WORD = IN_BUF_SIZE / 8;

  // Width of the in-block word counter and of the byte-count field.
  localparam int CNT_W    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int NBYTES_W = $clog2(BYTES_PER_WORD) + 1;

`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h01;
`endif
  localparam logic [7:0] PAD_LAST_BYTE  = 8'h80;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    PAD       = 2'd1,
    WAIT_DONE = 2'd2
  } pad_state_t;

endpackage : pkg_keccak
`default_nettype wire

// File: rtl/keccak_pad_word.sv
`default_nettype none
// ============================================================================
// Module    : keccak_pad_word
// Purpose   : Combinational byte mask and pad10*1 insertion for one word.
//             Bytes below byte_idx_i pass through, all others are zeroed.
//             Byte byte_idx_i receives the first pad byte when pad_start_i,
//             and the top byte is OR-ed with 0x80 when is_block_last_i.
// Ports     : word_i          - input word, little-endian bytes
//             byte_idx_i      - number of message bytes kept (0..BYTES_PER_WORD)
//             pad_start_i     - insert first pad byte at byte_idx_i
//             is_block_last_i - this word closes the rate block
//             word_o          - padded word
// Config    : pad byte value comes from pkg_keccak (KECCAK_PAD_SHA3_EN).
// Revision  : 1.0 - initial release
// ============================================================================
module keccak_pad_word
  import pkg_keccak::*;
(
  input  logic [IN_BUF_SIZE-1:0] word_i,
  input  logic [NBYTES_W-1:0]    byte_idx_i,
  input  logic                   pad_start_i,
  input  logic                   is_block_last_i,
  output logic [IN_BUF_SIZE-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (NBYTES_W'(k) < byte_idx_i) begin
        word_o[k*8 +: 8] = word_i[k*8 +: 8];
      end else if ((NBYTES_W'(k) == byte_idx_i) && pad_start_i) begin
        word_o[k*8 +: 8] = PAD_FIRST_BYTE;
      end
    end
    // OR rather than overwrite: the first pad byte may share the top byte.
    if (is_block_last_i) begin
      word_o[IN_BUF_SIZE-1 -: 8] = word_o[IN_BUF_SIZE-1 -: 8] | PAD_LAST_BYTE;
    end
  end

endmodule : keccak_pad_word
`default_nettype wire

// File: rtl/keccak_padder.sv
`default_nettype none
// ============================================================================
// Module    : keccak_padder
// Purpose   : Message-side front end of the Keccak-1024-rate datapath.
//             Passes message words through to keccak_buffer, applies pad10*1
//             at the rate boundary and raises Last_block once the final
//             padded block has been delivered.
// Ports     : Clock, Reset (sync, active-high)
//             Din/Din_valid/Din_last/Din_bytes/Din_ready - message stream in
//             Buffer_full, Ready - keccak_buffer full flag, permutation ready
//             Dout/Dout_valid - padded stream to keccak_buffer
//             Last_block      - final block delivered, held until released
// Config    : KECCAK_PAD_SHA3_EN - SHA-3 pad byte 0x06 (default 0x01).
// Revision  : 1.0 - initial release
// ============================================================================
module keccak_padder
  import pkg_keccak::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [IN_BUF_SIZE-1:0] Din,
  input  logic                   Din_valid,
  input  logic                   Din_last,
  input  logic [NBYTES_W-1:0]    Din_bytes,
  output logic                   Din_ready,
  input  logic                   Buffer_full,
  input  logic                   Ready,
  output logic [IN_BUF_SIZE-1:0] Dout,
  output logic                   Dout_valid,
  output logic                   Last_block
);

  localparam logic [NBYTES_W-1:0] FULL_BYTES = NBYTES_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(WPB - 1);

  pad_state_t       state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pad_start_q, pad_start_d;
  logic             last_block_q, last_block_d;

  logic [NBYTES_W-1:0]    bytes_clamped;
  logic                   last_partial;
  logic                   cnt_at_end;
  logic [CNT_W-1:0]       cnt_next;
  logic [IN_BUF_SIZE-1:0] pw_word;
  logic [NBYTES_W-1:0]    pw_idx;
  logic                   pw_pad;
  logic                   pw_last;

  // Oversized byte counts behave as a full word.
  assign bytes_clamped = (Din_bytes > FULL_BYTES) ? FULL_BYTES : Din_bytes;
  assign last_partial  = Din_last && (bytes_clamped < FULL_BYTES);
  assign cnt_at_end    = (word_cnt_q == CNT_LAST);
  assign cnt_next      = cnt_at_end ? '0 : (word_cnt_q + CNT_W'(1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ABSORB;
      word_cnt_q   <= '0;
      pad_start_q  <= 1'b0;
      last_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      pad_start_q  <= pad_start_d;
      last_block_q <= last_block_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    pad_start_d  = pad_start_q;
    last_block_d = last_block_q;
    Din_ready    = 1'b0;
    Dout_valid   = 1'b0;
    pw_word      = Din;
    pw_idx       = FULL_BYTES;
    pw_pad       = 1'b0;
    pw_last      = 1'b0;

    unique case (state_q)
      ABSORB: begin
        Din_ready  = ~Buffer_full;
        Dout_valid = Din_valid;
        // A partial final word carries the first pad byte, and closes the
        // block itself when it lands in the last slot.
        if (last_partial) begin
          pw_idx  = bytes_clamped;
          pw_pad  = 1'b1;
          pw_last = cnt_at_end;
        end
        if (Din_valid && !Buffer_full) begin
          word_cnt_d = cnt_next;
          if (Din_last) begin
            if (last_partial) begin
              state_d      = cnt_at_end ? WAIT_DONE : PAD;
              last_block_d = cnt_at_end;
            end else begin
              // Full final word: pad byte goes into the next (PAD) word,
              // which may be a whole extra block.
              pad_start_d = 1'b1;
              state_d     = PAD;
            end
          end
        end
      end

      PAD: begin
        Dout_valid = 1'b1;
        pw_word    = '0;
        pw_idx     = '0;
        pw_pad     = pad_start_q;
        pw_last    = cnt_at_end;
        if (!Buffer_full) begin
          pad_start_d = 1'b0;
          word_cnt_d  = cnt_next;
          if (cnt_at_end) begin
            state_d      = WAIT_DONE;
            last_block_d = 1'b1;
          end
        end
      end

      WAIT_DONE: begin
        if (Ready && Buffer_full) begin
          state_d      = ABSORB;
          last_block_d = 1'b0;
          word_cnt_d   = '0;
        end
      end

      default: begin
        state_d = ABSORB;
      end
    endcase

    if (Reset) begin
      Din_ready  = 1'b0;
      Dout_valid = 1'b0;
    end
  end

  keccak_pad_word u_pad_word (
    .word_i          (pw_word),
    .byte_idx_i      (pw_idx),
    .pad_start_i     (pw_pad),
    .is_block_last_i (pw_last),
    .word_o          (Dout)
  );

  assign Last_block = last_block_q;

endmodule : keccak_padder
`default_nettype wire

// File: tb/tb_keccak_padder.sv
`default_nettype none
// ============================================================================
// Module    : tb_keccak_padder
// Purpose   : Directed self-checking bench for keccak_padder (64-bit words,
//             1024-bit rate, 16 words per block).
// Config    : KECCAK_PAD_SHA3_EN switches the expected first pad byte.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_keccak_padder;

`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] P = 8'h06;
`else
  localparam logic [7:0] P = 8'h01;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] Din = '0;
  logic        Din_valid = 1'b0;
  logic        Din_last = 1'b0;
  logic [3:0]  Din_bytes = '0;
  logic        Din_ready;
  logic        Buffer_full = 1'b0;
  logic        Ready = 1'b0;
  logic [63:0] Dout;
  logic        Dout_valid;
  logic        Last_block;

  int checks   = 0;
  int failures = 0;

  keccak_padder dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Din_last    (Din_last),
    .Din_bytes   (Din_bytes),
    .Din_ready   (Din_ready),
    .Buffer_full (Buffer_full),
    .Ready       (Ready),
    .Dout        (Dout),
    .Dout_valid  (Dout_valid),
    .Last_block  (Last_block)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one word, check the combinational view, let it transfer.
  task automatic send_word(input string tag, input logic [63:0] data, input logic last,
                           input logic [3:0] nbytes, input logic [63:0] exp);
    Din       = data;
    Din_valid = 1'b1;
    Din_last  = last;
    Din_bytes = nbytes;
    @(negedge Clock);
    check({tag, " ready"}, {63'h0, Din_ready}, 64'h1);
    check({tag, " valid"}, {63'h0, Dout_valid}, 64'h1);
    check({tag, " dout"}, Dout, exp);
    @(posedge Clock); #1;
    Din_valid = 1'b0;
    Din_last  = 1'b0;
  endtask

  task automatic send_full(input string tag, input int n);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {32'hCAFE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
      send_word($sformatf("%s w%0d", tag, i), d, 1'b0, 4'd8, d);
    end
  endtask

  // Consume n PAD words with Buffer_full low.
  task automatic run_pad(input string tag, input int n, input logic first, input logic ends_block);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      e = 64'h0;
      if (i == 0 && first) e[7:0] = P;
      if (i == n - 1 && ends_block) e[63:56] = e[63:56] | 8'h80;
      @(negedge Clock);
      check($sformatf("%s pad%0d valid", tag, i), {63'h0, Dout_valid}, 64'h1);
      check($sformatf("%s pad%0d ready", tag, i), {63'h0, Din_ready}, 64'h0);
      check($sformatf("%s pad%0d lastblk", tag, i), {63'h0, Last_block}, 64'h0);
      check($sformatf("%s pad%0d dout", tag, i), Dout, e);
      @(posedge Clock); #1;
    end
  endtask

  // Expect WAIT_DONE, then release it with Ready & Buffer_full.
  task automatic exit_wait(input string tag);
    @(negedge Clock);
    check({tag, " lastblk"}, {63'h0, Last_block}, 64'h1);
    check({tag, " wait valid"}, {63'h0, Dout_valid}, 64'h0);
    check({tag, " wait ready"}, {63'h0, Din_ready}, 64'h0);
    Ready = 1'b1; Buffer_full = 1'b0;
    @(posedge Clock); #1;
    @(negedge Clock);
    check({tag, " ready-only hold"}, {63'h0, Last_block}, 64'h1);
    Ready = 1'b0; Buffer_full = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    check({tag, " full-only hold"}, {63'h0, Last_block}, 64'h1);
    Ready = 1'b1; Buffer_full = 1'b1;
    @(posedge Clock); #1;
    Ready = 1'b0; Buffer_full = 1'b0;
    @(negedge Clock);
    check({tag, " released"}, {63'h0, Last_block}, 64'h0);
    check({tag, " absorb ready"}, {63'h0, Din_ready}, 64'h1);
    @(posedge Clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge Clock);
    #1;
    @(negedge Clock);
    check("rst ready", {63'h0, Din_ready}, 64'h0);
    check("rst valid", {63'h0, Dout_valid}, 64'h0);
    check("rst lastblk", {63'h0, Last_block}, 64'h0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("idle ready", {63'h0, Din_ready}, 64'h1);
    Buffer_full = 1'b1;
    @(negedge Clock);
    check("full blocks ready", {63'h0, Din_ready}, 64'h0);
    @(posedge Clock); #1;
    Buffer_full = 1'b0;

    // Empty message.
    send_word("empty", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, {56'h0, P});
    run_pad("empty", 15, 1'b0, 1'b1);
    exit_wait("empty");

    // 3-byte message.
    send_word("b3", 64'hDEAD_BEEF_00AA_BBCC, 1'b1, 4'd3, {32'h0, P, 24'hAA_BBCC});
    run_pad("b3", 15, 1'b0, 1'b1);
    exit_wait("b3");

    // Partial final word in the last slot of the block.
    send_full("slot15", 15);
    send_word("slot15 last", 64'h1122_3344_5566_7788, 1'b1, 4'd7,
              {P | 8'h80, 56'h22_3344_5566_7788});
    exit_wait("slot15");

    // 128-byte message, final byte count oversized (clamped to full).
    send_full("m128", 15);
    send_word("m128 last", 64'h0055_6677_8899_AABB, 1'b1, 4'd15, 64'h0055_6677_8899_AABB);
    run_pad("m128", 16, 1'b1, 1'b1);
    exit_wait("m128");

    // Back-pressure on the first PAD word after a full final word.
    send_word("stall last", 64'h0102_0304_0506_0708, 1'b1, 4'd8, 64'h0102_0304_0506_0708);
    Buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check($sformatf("stall%0d dout", i), Dout, {56'h0, P});
      check($sformatf("stall%0d valid", i), {63'h0, Dout_valid}, 64'h1);
      @(posedge Clock); #1;
    end
    Buffer_full = 1'b0;
    run_pad("stall", 15, 1'b1, 1'b1);
    exit_wait("stall");

    // Reset while PAD word 7 is on the output.
    send_word("rst msg", 64'h0, 1'b1, 4'd0, {56'h0, P});
    run_pad("rst msg", 6, 1'b0, 1'b0);
    @(negedge Clock);
    check("pre-rst valid", {63'h0, Dout_valid}, 64'h1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    check("in-rst valid", {63'h0, Dout_valid}, 64'h0);
    check("in-rst ready", {63'h0, Din_ready}, 64'h0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("post-rst lastblk", {63'h0, Last_block}, 64'h0);
    check("post-rst ready", {63'h0, Din_ready}, 64'h1);
    check("post-rst valid", {63'h0, Dout_valid}, 64'h0);
    @(posedge Clock); #1;
    send_full("after rst", 1);
    send_word("after rst last", 64'hAABB_CCDD_EEFF_0011, 1'b1, 4'd5,
              {16'h0, P, 40'hDD_EEFF_0011});
    run_pad("after rst", 14, 1'b0, 1'b1);
    exit_wait("after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_keccak_padder
`default_nettype wire
